// File: rtl/iiitb_vm.sv
`default_nettype none
// ============================================================================
// Module      : iiitb_vm
// Description : Coin-operated vending machine controller. Sells one product
//               priced at 15 units and accepts 5- and 10-unit coins. Credit
//               accumulates in a 2-bit state register (0, 5 or 10 units). A
//               completed sale raises a one-cycle dispense pulse. When 20
//               units have been paid, the sale also returns 5 units of change.
// Ports       :
//   clk        in   1  system clock, rising-edge active
//   rst        in   1  asynchronous active-low reset
//   in         in   2  coin code: 00 none, 01 five, 10 ten, 11 invalid
//   out        out  1  dispense pulse, one cycle per completed sale
//   change     out  2  change code valid with out: 00 none, 01 five returned
// Revision    : 1.0  initial release
// ============================================================================
module iiitb_vm (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       out,
    output logic [1:0] change
);

    // Accumulated credit. Code 11 cannot be reached; if an upset lands the
    // register there, the next edge recovers it to S0.
    typedef enum logic [1:0] {
        S0        = 2'b00,
        S5        = 2'b01,
        S10       = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    localparam logic [1:0] c_COIN_NONE = 2'b00;
    localparam logic [1:0] c_COIN_5    = 2'b01;
    localparam logic [1:0] c_COIN_10   = 2'b10;
    localparam logic [1:0] c_COIN_BAD  = 2'b11;

    localparam logic [1:0] c_CHG_NONE  = 2'b00;
    localparam logic [1:0] c_CHG_5     = 2'b01;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_out;
    logic       w_out;
    logic [1:0] r_change;
    logic [1:0] w_change;

    // State and registered outputs. The outputs are registered so that the
    // dispense pulse and change code appear one edge after the deciding coin.
    // The outputs are also cleared asynchronously, so a reset aborts a
    // dispense pulse that is already visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S0;
            r_out    <= 1'b0;
            r_change <= c_CHG_NONE;
        end else begin
            r_state  <= w_next_state;
            r_out    <= w_out;
            r_change <= w_change;
        end
    end

    // Next-state and next-output decode. The default is to hold credit with
    // no sale. Idle and invalid coins therefore need no action of their own.
    always_comb begin
        w_next_state = r_state;
        w_out        = 1'b0;
        w_change     = c_CHG_NONE;

        case (r_state)
            S0: begin
                case (in)
                    c_COIN_5:    w_next_state = S5;
                    c_COIN_10:   w_next_state = S10;
                    c_COIN_NONE: w_next_state = S0;
                    c_COIN_BAD:  w_next_state = S0;
                endcase
            end

            S5: begin
                case (in)
                    c_COIN_5:    w_next_state = S10;
                    c_COIN_10: begin
                        // Exactly 15 paid.
                        w_next_state = S0;
                        w_out        = 1'b1;
                    end
                    c_COIN_NONE: w_next_state = S5;
                    c_COIN_BAD:  w_next_state = S5;
                endcase
            end

            S10: begin
                case (in)
                    c_COIN_5: begin
                        // Exactly 15 paid.
                        w_next_state = S0;
                        w_out        = 1'b1;
                    end
                    c_COIN_10: begin
                        // 20 paid, so 5 units are returned.
                        w_next_state = S0;
                        w_out        = 1'b1;
                        w_change     = c_CHG_5;
                    end
                    c_COIN_NONE: w_next_state = S10;
                    c_COIN_BAD:  w_next_state = S10;
                endcase
            end

            default: begin
                // Unreachable code: recover with no sale.
                w_next_state = S0;
            end
        endcase
    end

    assign out    = r_out;
    assign change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_iiitb_vm.sv
`default_nettype none
// ============================================================================
// Module      : tb_iiitb_vm
// Description : Directed self-checking bench for iiitb_vm. Each scenario task
//               drives coin codes and compares out/change 1 time unit after
//               each rising edge against hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_iiitb_vm;

    logic       clk;
    logic       rst;
    logic [1:0] tb_in;
    logic       w_out;
    logic [1:0] w_change;

    int n_tests;
    int n_fail;

    iiitb_vm dut (
        .clk    (clk),
        .rst    (rst),
        .in     (tb_in),
        .out    (w_out),
        .change (w_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one coin code and advance to just after the next rising edge.
    task automatic step(input logic [1:0] coin);
        tb_in = coin;
        @(posedge clk);
        #1;
    endtask

    // Outputs must be 0/00 whenever rst is low, with or without clock edges.
    task automatic test_reset();
        rst   = 1'b0;
        tb_in = 2'b00;
        #2;
        n_tests++;
        if (w_out !== 1'b0 || w_change !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_async out=%b change=%b expected out=0 change=00", w_out, w_change);
        end
        for (int i = 0; i < 4; i++) begin
            step(2'(i));
            n_tests++;
            if (w_out !== 1'b0 || w_change !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold[%0d] out=%b change=%b expected out=0 change=00", i, w_out, w_change);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(2'b00);
            n_tests++;
            if (w_out !== 1'b0 || w_change !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_idle[%0d] out=%b change=%b expected out=0 change=00", i, w_out, w_change);
            end
        end
    endtask

    // 10,10 then idle: sale with 5 change on edge 2, cleared on edge 3.
    task automatic test_double_ten();
        logic [5:0] coins;
        logic [2:0] e_out;
        logic [5:0] e_chg;
        coins = {2'b00, 2'b10, 2'b10};
        e_out = 3'b010;
        e_chg = {2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 3; i++) begin
            step(coins[2*i +: 2]);
            n_tests++;
            if (w_out !== e_out[i] || w_change !== e_chg[2*i +: 2]) begin
                n_fail++;
                $display("FAIL double_ten[%0d] out=%b change=%b expected out=%b change=%b",
                         i, w_out, w_change, e_out[i], e_chg[2*i +: 2]);
            end
        end
    endtask

    // 5,5,5: exact 15 on the third coin.
    task automatic test_exact_fives();
        logic [2:0] e_out;
        e_out = 3'b100;
        for (int i = 0; i < 3; i++) begin
            step(2'b01);
            n_tests++;
            if (w_out !== e_out[i] || w_change !== 2'b00) begin
                n_fail++;
                $display("FAIL exact_fives[%0d] out=%b change=%b expected out=%b change=00",
                         i, w_out, w_change, e_out[i]);
            end
        end
    endtask

    // 5,10 then 10,5 (exact sales) then 10,10 (sale with change).
    task automatic test_mixed();
        logic [11:0] coins;
        logic [5:0]  e_out;
        logic [11:0] e_chg;
        coins = {2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        e_out = 6'b101010;
        e_chg = {2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 6; i++) begin
            step(coins[2*i +: 2]);
            n_tests++;
            if (w_out !== e_out[i] || w_change !== e_chg[2*i +: 2]) begin
                n_fail++;
                $display("FAIL mixed[%0d] out=%b change=%b expected out=%b change=%b",
                         i, w_out, w_change, e_out[i], e_chg[2*i +: 2]);
            end
        end
        step(2'b00);
        n_tests++;
        if (w_out !== 1'b0 || w_change !== 2'b00) begin
            n_fail++;
            $display("FAIL mixed_clear out=%b change=%b expected out=0 change=00", w_out, w_change);
        end
    endtask

    // 5, invalid, idle, 5, 5: the invalid code adds nothing, so the sale lands on the last coin.
    task automatic test_invalid_idle();
        logic [9:0] coins;
        logic [4:0] e_out;
        coins = {2'b01, 2'b01, 2'b00, 2'b11, 2'b01};
        e_out = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            step(coins[2*i +: 2]);
            n_tests++;
            if (w_out !== e_out[i] || w_change !== 2'b00) begin
                n_fail++;
                $display("FAIL invalid_idle[%0d] out=%b change=%b expected out=%b change=00",
                         i, w_out, w_change, e_out[i]);
            end
        end
    endtask

    // 10,10,10,10: two back-to-back sales, each returning change.
    task automatic test_back_to_back();
        logic [3:0] e_out;
        logic [7:0] e_chg;
        e_out = 4'b1010;
        e_chg = {2'b01, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            step(2'b10);
            n_tests++;
            if (w_out !== e_out[i] || w_change !== e_chg[2*i +: 2]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] out=%b change=%b expected out=%b change=%b",
                         i, w_out, w_change, e_out[i], e_chg[2*i +: 2]);
            end
        end
        step(2'b00);
    endtask

    // Reset mid-transaction at 10 credit. Credit must be lost: 5 then 10 must
    // then sell exactly (S5 -> sale), not sell on the 5.
    task automatic test_async_reset();
        step(2'b10);
        #3;
        rst = 1'b0;
        #1;
        n_tests++;
        if (w_out !== 1'b0 || w_change !== 2'b00) begin
            n_fail++;
            $display("FAIL async_mid out=%b change=%b expected out=0 change=00", w_out, w_change);
        end
        step(2'b10);
        n_tests++;
        if (w_out !== 1'b0 || w_change !== 2'b00) begin
            n_fail++;
            $display("FAIL async_hold out=%b change=%b expected out=0 change=00", w_out, w_change);
        end
        rst = 1'b1;
        step(2'b01);
        n_tests++;
        if (w_out !== 1'b0 || w_change !== 2'b00) begin
            n_fail++;
            $display("FAIL async_credit_cleared out=%b change=%b expected out=0 change=00", w_out, w_change);
        end
        step(2'b10);
        n_tests++;
        if (w_out !== 1'b1 || w_change !== 2'b00) begin
            n_fail++;
            $display("FAIL async_after_sale out=%b change=%b expected out=1 change=00", w_out, w_change);
        end
        step(2'b00);
    endtask

    // Reset asserted while out=1 must drop the dispense pulse without an edge.
    task automatic test_reset_during_sale();
        step(2'b10);
        step(2'b10);
        n_tests++;
        if (w_out !== 1'b1 || w_change !== 2'b01) begin
            n_fail++;
            $display("FAIL sale_before_reset out=%b change=%b expected out=1 change=01", w_out, w_change);
        end
        tb_in = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (w_out !== 1'b0 || w_change !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_during_sale out=%b change=%b expected out=0 change=00", w_out, w_change);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(2'b01);
        n_tests++;
        if (w_out !== 1'b0 || w_change !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_five out=%b change=%b expected out=0 change=00", w_out, w_change);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        tb_in   = 2'b00;
        test_reset();
        test_double_ten();
        test_exact_fives();
        test_mixed();
        test_invalid_idle();
        test_back_to_back();
        test_async_reset();
        test_reset_during_sale();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
